// File: rtl/sata_prim_pkg.sv
// Shared SATA link-layer definitions: primitive dwords, primitive codes, CRC and
// scrambler constants, and the combinational decode/CRC helpers.
package sata_prim_pkg;

  localparam int unsigned MaxDwDefault = 2049;

  localparam logic [31:0] CrcInit = 32'h5232_5032;
  localparam logic [31:0] CrcPoly = 32'h04C1_1DB7;

  // x^16 + x^15 + x^13 + x^4 + 1, low 16 taps
  localparam logic [15:0] ScrSeed = 16'hFFFF;
  localparam logic [15:0] ScrPoly = 16'hA011;

  localparam logic [31:0] DwAlign  = 32'h7B4A_4ABC;
  localparam logic [31:0] DwCont   = 32'h9999_AA7C;
  localparam logic [31:0] DwDmat   = 32'h3636_B57C;
  localparam logic [31:0] DwEof    = 32'hD5D5_B57C;
  localparam logic [31:0] DwHold   = 32'hD5D5_AA7C;
  localparam logic [31:0] DwHolda  = 32'h9595_AA7C;
  localparam logic [31:0] DwPmack  = 32'h9595_957C;
  localparam logic [31:0] DwPmnak  = 32'hF5F5_957C;
  localparam logic [31:0] DwPmreqP = 32'h1717_B57C;
  localparam logic [31:0] DwPmreqS = 32'h7575_957C;
  localparam logic [31:0] DwRErr   = 32'h5656_B57C;
  localparam logic [31:0] DwRIp    = 32'h5555_B57C;
  localparam logic [31:0] DwROk    = 32'h3535_B57C;
  localparam logic [31:0] DwRRdy   = 32'h4A4A_957C;
  localparam logic [31:0] DwSof    = 32'h3737_B57C;
  localparam logic [31:0] DwSync   = 32'hB5B5_957C;
  localparam logic [31:0] DwWtrm   = 32'h5858_B57C;
  localparam logic [31:0] DwXRdy   = 32'h5757_B57C;

  typedef enum logic [4:0] {
    PrimNone   = 5'd0,
    PrimSync   = 5'd1,
    PrimXRdy   = 5'd2,
    PrimRRdy   = 5'd3,
    PrimSof    = 5'd4,
    PrimEof    = 5'd5,
    PrimWtrm   = 5'd6,
    PrimHold   = 5'd7,
    PrimHolda  = 5'd8,
    PrimRIp    = 5'd9,
    PrimROk    = 5'd10,
    PrimRErr   = 5'd11,
    PrimDmat   = 5'd12,
    PrimPmreqP = 5'd13,
    PrimPmreqS = 5'd14,
    PrimPmack  = 5'd15,
    PrimPmnak  = 5'd16,
    PrimCont   = 5'd17,
    PrimAlign  = 5'd18
  } prim_e;

  // Full-dword match; PrimNone marks an unknown K dword.
  function automatic prim_e prim_decode(input logic [31:0] dw);
    prim_e code;
    case (dw)
      DwSync:   code = PrimSync;
      DwXRdy:   code = PrimXRdy;
      DwRRdy:   code = PrimRRdy;
      DwSof:    code = PrimSof;
      DwEof:    code = PrimEof;
      DwWtrm:   code = PrimWtrm;
      DwHold:   code = PrimHold;
      DwHolda:  code = PrimHolda;
      DwRIp:    code = PrimRIp;
      DwROk:    code = PrimROk;
      DwRErr:   code = PrimRErr;
      DwDmat:   code = PrimDmat;
      DwPmreqP: code = PrimPmreqP;
      DwPmreqS: code = PrimPmreqS;
      DwPmack:  code = PrimPmack;
      DwPmnak:  code = PrimPmnak;
      DwCont:   code = PrimCont;
      DwAlign:  code = PrimAlign;
      default:  code = PrimNone;
    endcase
    return code;
  endfunction

  // One dword folded MSB-first, no reflection, no final xor.
  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [31:0] dw);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ dw[i]) c = {c[30:0], 1'b0} ^ CrcPoly;
      else               c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_scrambler.sv
// SATA frame scrambler: 16-bit LFSR producing one 32-bit mask per advance.
// Shared with the transmit path.
module sata_scrambler
  import sata_prim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reseed,
  input  logic        advance,
  output logic [31:0] mask
);

  logic [15:0] ctx_q;
  logic [15:0] ctx_step;

  // Galois form: mask bit i is the LFSR MSB before the i-th shift.
  always_comb begin
    ctx_step = ctx_q;
    mask     = '0;
    for (int i = 0; i < 32; i++) begin
      mask[i]  = ctx_step[15];
      ctx_step = {ctx_step[14:0], 1'b0} ^ (ctx_step[15] ? ScrPoly : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || reseed) begin
      ctx_q <= ScrSeed;
    end else if (advance) begin
      ctx_q <= ctx_step;
    end
  end

endmodule

// File: rtl/host_link_rx.sv
// Host SATA link receive front end: primitive decode, ALIGN/CONT handling,
// frame descrambling, CRC check and one-dword holdback so the CRC is never delivered.
module host_link_rx
  import sata_prim_pkg::*;
#(
  parameter int unsigned MAX_DW = MaxDwDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_up,
  input  logic [31:0] rx_data,
  input  logic        rx_charisk,
  output logic [4:0]  prim,
  output logic        prim_valid,
  output logic        prim_illegal,
  output logic [31:0] fr_data,
  output logic        fr_valid,
  output logic        fr_sof,
  output logic        fr_end,
  output logic        fr_crc_ok,
  output logic        fr_err
);

  localparam int unsigned CntW = $clog2(MAX_DW + 3);

  typedef enum logic {StIdle, StFrame} state_e;

  state_e          state;
  prim_e           prim_q;
  logic            cont_act;
  logic            hold_v;
  logic            sof_pend;
  logic [31:0]     hold;
  logic [31:0]     crc;
  logic [CntW-1:0] count;

  prim_e       code;
  logic        is_sof;
  logic        is_data;
  logic        overflow;
  logic [31:0] mask;
  logic [31:0] desc;
  logic [31:0] crc_upd;

  assign code     = prim_decode(rx_data);
  assign is_sof   = link_up && rx_charisk && (code == PrimSof);
  assign is_data  = link_up && !rx_charisk && !cont_act && (state == StFrame);
  // Count includes the CRC dword, so MAX_DW + 1 dwords are legal.
  assign overflow = (count == CntW'(MAX_DW + 1));
  assign desc     = rx_data ^ mask;
  assign crc_upd  = crc_next(crc, desc);
  assign prim     = prim_q;

  sata_scrambler u_scrambler (
    .clk     (clk),
    .rst_n   (rst_n),
    .reseed  (is_sof),
    .advance (is_data && !overflow),
    .mask    (mask)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= StIdle;
      prim_q       <= PrimNone;
      prim_valid   <= 1'b0;
      prim_illegal <= 1'b0;
      fr_data      <= '0;
      fr_valid     <= 1'b0;
      fr_sof       <= 1'b0;
      fr_end       <= 1'b0;
      fr_crc_ok    <= 1'b0;
      fr_err       <= 1'b0;
      cont_act     <= 1'b0;
      hold_v       <= 1'b0;
      sof_pend     <= 1'b0;
      hold         <= '0;
      crc          <= CrcInit;
      count        <= '0;
    end else begin
      prim_valid   <= 1'b0;
      prim_illegal <= 1'b0;
      fr_valid     <= 1'b0;
      fr_sof       <= 1'b0;
      fr_end       <= 1'b0;
      fr_crc_ok    <= 1'b0;
      fr_err       <= 1'b0;

      if (!link_up) begin
        // Only the abort of an open frame is signalled while the link is down.
        if (state == StFrame) begin
          fr_end <= 1'b1;
          fr_err <= 1'b1;
        end
        state    <= StIdle;
        cont_act <= 1'b0;
        hold_v   <= 1'b0;
      end else if (rx_charisk) begin
        if (code == PrimNone) begin
          prim_illegal <= 1'b1;
        end else if (code == PrimCont) begin
          cont_act <= 1'b1;
        end else if (code != PrimAlign) begin
          cont_act   <= 1'b0;
          prim_q     <= code;
          prim_valid <= 1'b1;
          if (code == PrimSof) begin
            if (state == StFrame) begin
              fr_end <= 1'b1;
              fr_err <= 1'b1;
            end
            state    <= StFrame;
            crc      <= CrcInit;
            count    <= '0;
            hold     <= '0;
            hold_v   <= 1'b0;
            sof_pend <= 1'b1;
          end else if (code == PrimEof && state == StFrame) begin
            // The held dword is the CRC and is dropped here.
            fr_end    <= 1'b1;
            fr_crc_ok <= (crc == '0);
            state     <= StIdle;
            hold_v    <= 1'b0;
          end
        end
      end else if (is_data) begin
        if (overflow) begin
          fr_end <= 1'b1;
          fr_err <= 1'b1;
          state  <= StIdle;
          hold_v <= 1'b0;
        end else begin
          crc    <= crc_upd;
          count  <= count + CntW'(1);
          hold   <= desc;
          hold_v <= 1'b1;
          if (hold_v) begin
            fr_data  <= hold;
            fr_valid <= 1'b1;
            fr_sof   <= sof_pend;
            sof_pend <= 1'b0;
          end
        end
      end
    end
  end

endmodule
